// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared constants, encodings and state type for mem_access_ctrl
// Optional feature macro used by the controller: MISALIGN_TRAP_EN
package mem_access_ctrl_pkg;

   localparam int AWIDTH_DEF = 12;
   localparam int DWIDTH_DEF = 32;

   localparam logic [2:0] F3_B       = 3'b000;
   localparam logic [2:0] F3_H       = 3'b001;
   localparam logic [2:0] F3_W       = 3'b010;
   localparam logic [2:0] F3_D       = 3'b011;
   localparam logic [2:0] F3_BU      = 3'b100;
   localparam logic [2:0] F3_HU      = 3'b101;
   localparam logic [2:0] F3_WU      = 3'b110;
   localparam logic [2:0] F3_ILLEGAL = 3'b111;

   localparam logic [1:0] SIZE_BYTE   = 2'b00;
   localparam logic [1:0] SIZE_HALF   = 2'b01;
   localparam logic [1:0] SIZE_WORD   = 2'b10;
   localparam logic [1:0] SIZE_DOUBLE = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_RESP    = 2'd3
   } state_e;

   // True when the low address bits are not a multiple of the access size.
   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo);
      logic m;
      m = 1'b0;
      case (size)
         SIZE_BYTE:   m = 1'b0;
         SIZE_HALF:   m = lo[0];
         SIZE_WORD:   m = (lo[1:0] != 2'b00);
         SIZE_DOUBLE: m = (lo != 3'b000);
         default:     m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// rtl/mem_access_ctrl_load_extend.sv - combinational sign/zero extension of RAM read data by funct3
module load_extend
   import mem_access_ctrl_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF
) (
   input  logic [2:0]        funct3,
   input  logic [DWIDTH-1:0] raw,
   output logic [DWIDTH-1:0] ext
);

   always_comb begin
      ext = '0;
      case (funct3)
         F3_B:    ext = DWIDTH'($signed(raw[7:0]));
         F3_H:    ext = DWIDTH'($signed(raw[15:0]));
         F3_W:    ext = DWIDTH'($signed(raw[31:0]));
         F3_D:    ext = raw;
         F3_BU:   ext = DWIDTH'(raw[7:0]);
         F3_HU:   ext = DWIDTH'(raw[15:0]);
         F3_WU:   ext = DWIDTH'(raw[31:0]);
         default: ext = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - one-at-a-time load/store controller in front of a registered-read data RAM
// Define MISALIGN_TRAP_EN to reject accesses not aligned to their size.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int DWIDTH = DWIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   input  logic [4:0]        req_rd,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DWIDTH-1:0] rsp_rdata,
   output logic [4:0]        rsp_rd,
   output logic              rsp_fault,
   output logic [AWIDTH-1:0] ram_addr,
   output logic [DWIDTH-1:0] ram_qin,
   output logic [2:0]        ram_we,
   input  logic [DWIDTH-1:0] ram_qout
);

   state_e            state_q, state_d;
   logic              store_q, store_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;
   logic [4:0]        rd_q, rd_d;
   logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_fault_q, rsp_fault_d;
   logic [DWIDTH-1:0] ext_data;
   logic              reject;

   load_extend #(.DWIDTH(DWIDTH)) u_load_extend (
      .funct3 (funct3_q),
      .raw    (ram_qout),
      .ext    (ext_data)
   );

   always_comb begin
      reject = 1'b0;
      if (!req_store && req_funct3 == F3_ILLEGAL) reject = 1'b1;
      if (DWIDTH == 32 && req_funct3[1:0] == SIZE_DOUBLE) reject = 1'b1;
      if (DWIDTH == 32 && !req_store && req_funct3 == F3_WU) reject = 1'b1;
`ifdef MISALIGN_TRAP_EN
      if (misaligned(req_funct3[1:0], req_addr[2:0])) reject = 1'b1;
`endif
   end

   always_comb begin
      state_d     = state_q;
      store_d     = store_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rd_d        = rd_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_fault_d = rsp_fault_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               store_d     = req_store;
               funct3_d    = req_funct3;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               rd_d        = req_rd;
               rsp_rdata_d = '0;
               rsp_fault_d = reject;
               state_d     = reject ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE:   state_d = store_q ? S_RESP : S_CAPTURE;
         S_CAPTURE: begin
            rsp_rdata_d = ext_data;
            state_d     = S_RESP;
         end
         S_RESP:    if (rsp_ready) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         store_q     <= 1'b0;
         funct3_q    <= 3'b000;
         addr_q      <= '0;
         wdata_q     <= '0;
         rd_q        <= 5'd0;
         rsp_rdata_q <= '0;
         rsp_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         store_q     <= store_d;
         funct3_q    <= funct3_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rd_q        <= rd_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_fault_q <= rsp_fault_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_rd    = rd_q;
   assign rsp_fault = rsp_fault_q;
   assign ram_addr  = addr_q;
   assign ram_qin   = wdata_q;
   // Gated by rst_n directly so a reset edge landing on ISSUE cannot write the RAM.
   assign ram_we    = (rst_n && state_q == S_ISSUE && store_q) ? {1'b1, funct3_q[1:0]} : 3'b000;

endmodule
